// File: rtl/bnn_pkg.sv
// Shared constants and types for the binary MLP classifier back end.
// Covers layer geometry, the argmax FSM state encoding and the result record.
package bnn_pkg;

  localparam int BNN_INPUT_SIZE  = 784;
  localparam int BNN_NUM_CLASSES = 10;
  localparam int BNN_SCORE_WIDTH = $clog2(BNN_INPUT_SIZE + 1);
  localparam int BNN_IDX_WIDTH   = $clog2(BNN_NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } argmax_state_t;

  // "class" is a reserved word, hence class_idx
  typedef struct packed {
    logic [BNN_IDX_WIDTH-1:0]   class_idx;
    logic [BNN_SCORE_WIDTH-1:0] score;
    logic                       err;
  } argmax_result_t;

endpackage

// File: rtl/bnn_argmax_stream.sv
// Streaming argmax over one class score per beat; result valid the cycle after the ending beat.
// Input is stalled (in_ready=0) while a result waits in HOLD for out_ready.
module bnn_argmax_stream
  import bnn_pkg::*;
#(
  parameter int NUM_CLASSES = BNN_NUM_CLASSES,
  parameter int SCORE_WIDTH = BNN_SCORE_WIDTH,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SCORE_WIDTH-1:0] in_score,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_WIDTH-1:0]   out_class,
  output logic [SCORE_WIDTH-1:0] out_score,
  output logic                   out_err
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  argmax_state_t          state;
  argmax_state_t          state_nxt;
  logic [IDX_WIDTH-1:0]   cnt;
  logic [SCORE_WIDTH-1:0] max_score;
  logic [IDX_WIDTH-1:0]   max_idx;
  logic                   err;

  logic accept;
  logic final_beat;
  logic frame_end;

  assign accept     = in_valid & in_ready & ~clear;
  assign final_beat = (cnt == LAST_IDX);
  assign frame_end  = accept & (final_beat | in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (frame_end) begin
          state_nxt = HOLD;
        end else if (accept) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (frame_end) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt = IDLE;
    end
  end

  // in_ready is a function of state only; rst_n gating keeps it low during reset
  always_comb begin
    in_ready  = rst_n && (state != HOLD);
    out_valid = (state == HOLD);
  end

  // First beat of a frame loads unconditionally; later beats need a strict win,
  // so the lowest index keeps a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      max_score <= '0;
      max_idx   <= '0;
      err       <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        max_score <= in_score;
        max_idx   <= '0;
      end else if (in_score > max_score) begin
        max_score <= in_score;
        max_idx   <= cnt;
      end
      cnt <= frame_end ? '0 : cnt + 1'b1;
      if (frame_end) begin
        err <= in_last ^ final_beat;
      end
    end
  end

  assign out_class = max_idx;
  assign out_score = max_score;
  assign out_err   = err;

endmodule

// File: tb/tb_bnn_argmax_stream.sv
// Randomised bench for bnn_argmax_stream against a queue-based argmax reference.
module tb_bnn_argmax_stream;
  import bnn_pkg::*;

  localparam int NC = BNN_NUM_CLASSES;
  localparam int SW = BNN_SCORE_WIDTH;
  localparam int IW = $clog2(NC);

  typedef logic [SW-1:0] score_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  score_t        in_score;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  score_t        out_score;
  logic          out_err;

  int n_cmp     = 0;
  int n_mis     = 0;
  int n_results = 0;
  int n_frames  = 0;

  score_t         cur_q[$];
  argmax_result_t exp_q[$];
  argmax_result_t got;
  argmax_result_t prev;
  bit             vld_due;
  bit             hs_done;
  bit             prev_hold;

  always #5 clk = ~clk;

  bnn_argmax_stream #(
    .NUM_CLASSES(NC),
    .SCORE_WIDTH(SW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_score (in_score),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_score(out_score),
    .out_err  (out_err)
  );

  task automatic check_eq(input string tag, input int got_v, input int exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  // Reference: largest score, earliest index holding it, error if the frame
  // length and the in_last marker disagree.
  function automatic argmax_result_t model_frame(input score_t q[$], input bit last);
    argmax_result_t r;
    int best;
    best = 0;
    foreach (q[i]) if (int'(q[i]) > best) best = int'(q[i]);
    r.score     = SW'(best);
    r.class_idx = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (int'(q[i]) == best) r.class_idx = IW'(i);
    end
    r.err = (last != (q.size() == NC));
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || clear) begin
      cur_q.delete();
      exp_q.delete();
      vld_due   = 1'b0;
      hs_done   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (vld_due) check_eq("latency_out_valid", int'(out_valid), 1);
      if (hs_done) check_eq("out_valid_one_cycle", int'(out_valid), 0);
      vld_due = 1'b0;
      hs_done = 1'b0;
      if (out_valid) begin
        check_eq("in_ready_in_hold", int'(in_ready), 0);
        if (prev_hold) begin
          check_eq("hold_class_stable", int'(out_class), int'(prev.class_idx));
          check_eq("hold_score_stable", int'(out_score), int'(prev.score));
          check_eq("hold_err_stable", int'(out_err), int'(prev.err));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_result", exp_q.size(), 1);
          end else begin
            check_eq("out_class", int'(out_class), int'(exp_q[0].class_idx));
            check_eq("out_score", int'(out_score), int'(exp_q[0].score));
            check_eq("out_err", int'(out_err), int'(exp_q[0].err));
            void'(exp_q.pop_front());
          end
          got.class_idx = out_class;
          got.score     = out_score;
          got.err       = out_err;
          n_results++;
          hs_done = 1'b1;
        end
        prev_hold       = !out_ready;
        prev.class_idx  = out_class;
        prev.score      = out_score;
        prev.err        = out_err;
      end else begin
        prev_hold = 1'b0;
      end
      if (in_valid && in_ready) begin
        cur_q.push_back(in_score);
        if (in_last || cur_q.size() == NC) begin
          exp_q.push_back(model_frame(cur_q, in_last));
          cur_q.delete();
          vld_due = 1'b1;
        end
      end
    end
  end

  task automatic send_beat(input score_t s, input logic l, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_score = s;
    in_last  = l;
    ok       = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("beat_accept_timeout", int'(ok), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_score = score_t'($urandom);
  endtask

  task automatic send_frame(input score_t sc[NC], input int n, input int last_pos,
                            input int max_gap);
    for (int i = 0; i < n; i++) send_beat(sc[i], (i == last_pos), max_gap);
  endtask

  task automatic wait_results(input int target);
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #2;
      if (n_results >= target) break;
    end
    check_eq("result_count", n_results, target);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #2;
      if (out_valid) break;
    end
    check_eq("hold_reached", int'(out_valid), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    check_eq({tag, "_out_class"}, int'(out_class), 0);
    check_eq({tag, "_out_score"}, int'(out_score), 0);
    check_eq({tag, "_out_err"}, int'(out_err), 0);
    check_eq({tag, "_in_ready"}, int'(in_ready), 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs(tag);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string tag, input int c, input int s, input int e);
    check_eq({tag, "_class"}, int'(got.class_idx), c);
    check_eq({tag, "_score"}, int'(got.score), s);
    check_eq({tag, "_err"}, int'(got.err), e);
  endtask

  initial begin
    score_t sc[NC];
    score_t sc2[NC];
    int     lp;

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_score  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sc = '{3, 10, 7, 1, 0, 5, 9, 500, 2, 4};
    send_frame(sc, NC, NC - 1, 0);
    n_frames++;
    wait_results(n_frames);
    check_got("basic", 7, 500, 0);

    sc = '{4, 4, 9, 2, 9, 0, 0, 9, 1, 1};
    send_frame(sc, NC, NC - 1, 2);
    n_frames++;
    wait_results(n_frames);
    check_got("ties", 2, 9, 0);

    sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(sc, NC, NC - 1, 1);
    n_frames++;
    wait_results(n_frames);
    check_got("zeros", 0, 0, 0);

    // Backpressure: second frame must stall until the first result is taken
    foreach (sc[i]) sc[i] = score_t'($urandom_range(784, 0));
    foreach (sc2[i]) sc2[i] = score_t'($urandom_range(784, 0));
    out_ready = 1'b0;
    send_frame(sc, NC, NC - 1, 3);
    fork
      send_frame(sc2, NC, NC - 1, 3);
      begin
        wait_out_valid();
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    n_frames += 2;
    wait_results(n_frames);

    sc = '{1, 2, 8, 3, 6, 0, 0, 0, 0, 0};
    send_frame(sc, 5, 4, 1);
    n_frames++;
    wait_results(n_frames);
    check_got("early_last", 2, 8, 1);

    sc = '{5, 1, 5, 9, 0, 9, 3, 2, 8, 1};
    send_frame(sc, NC, -1, 1);
    n_frames++;
    wait_results(n_frames);
    check_got("missing_last", 3, 9, 1);

    // Abort mid-frame; the big scores of the aborted frame must not leak
    sc = '{900, 900, 900, 900, 900, 900, 0, 0, 0, 0};
    send_frame(sc, 6, -1, 0);
    in_valid = 1'b1;
    in_score = score_t'(900);
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("clear_out_valid", int'(out_valid), 0);
    check_eq("clear_in_ready", int'(in_ready), 1);
    sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 784};
    send_frame(sc, NC, NC - 1, 0);
    n_frames++;
    wait_results(n_frames);
    check_got("after_clear", 9, 784, 0);

    for (int f = 0; f < 12; f++) begin
      foreach (sc[i]) sc[i] = score_t'((f % 2 == 0) ? $urandom_range(7, 0) : $urandom_range(784, 0));
      lp = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NC - 1, 0)) : NC - 1;
      send_frame(sc, lp + 1, lp, 2);
      n_frames++;
      wait_results(n_frames);
    end

    sc = '{700, 700, 700, 700, 0, 0, 0, 0, 0, 0};
    send_frame(sc, 4, -1, 0);
    pulse_reset("rst_mid_frame");

    out_ready = 1'b0;
    send_frame(sc, NC, NC - 1, 0);
    wait_out_valid();
    pulse_reset("rst_in_hold");
    out_ready = 1'b1;

    sc = '{11, 22, 33, 44, 55, 66, 77, 88, 99, 12};
    send_frame(sc, NC, NC - 1, 1);
    n_frames++;
    wait_results(n_frames);
    check_got("after_reset", 8, 99, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bnn_argmax_stream.md
Name: bnn_argmax_stream

Overview:
Sequential argmax stage placed directly downstream of the binary MLP classification layer. It receives the per-class popcount scores as a valid/ready stream, one class per beat in class order, and tracks the running maximum. It then presents the winning class index and its score on a registered output with a valid/ready handshake. It replaces the flat combinational comparator, so the design needs one magnitude comparator instead of a NUM_CLASSES-deep compare chain.

Parameters:
NUM_CLASSES, 10, number of class scores per frame (must be >= 2)
SCORE_WIDTH, 10, popcount width; equals $clog2(784+1) for a 784-input layer
IDX_WIDTH, $clog2(NUM_CLASSES), width of the class index

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; drops the current frame and any held result
in_valid  input  1  in_score and in_last are valid
in_ready  output  1  stage can accept a beat
in_score  input  SCORE_WIDTH  popcount of the current class (class = beat index in frame)
in_last  input  1  producer marks the final class of the frame
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_class  output  IDX_WIDTH  index of the maximum score
out_score  output  SCORE_WIDTH  maximum score value
out_err  output  1  frame length mismatch flag, qualified by out_valid

Behaviour:
- Reset (rst_n low, async): state=IDLE, beat counter=0, running max/index=0. out_valid=0, out_class=0, out_score=0, out_err=0, in_ready=0 during reset.
- States:
  - IDLE: in_ready=1, no frame in progress. An accepted beat (in_valid & in_ready) loads the max unconditionally with index 0, then goes to COLLECT. If that beat also ends the frame, go straight to HOLD.
  - COLLECT: in_ready=1. On each accepted beat, count k=counter+1. Update the max only if in_score > current max (strict compare, so the lowest index wins a tie).
  - HOLD: in_ready=0, out_valid=1. Outputs are stable until out_valid & out_ready, then go to IDLE on the next edge.
- A frame ends on the accepted beat where counter==NUM_CLASSES-1 or in_last=1, whichever comes first.
- out_err=1 when in_last disagrees with counter==NUM_CLASSES-1 on the ending beat. This covers both an early in_last and a missing in_last on the final class. The result of an errored frame is still the argmax over the beats received.
- All-zero scores give out_class=0, out_score=0, because the first beat always loads. The result is never undefined or latched.
- Latency: ending beat accepted at edge N gives out_valid=1 after edge N. Throughput is NUM_CLASSES+1 cycles per frame with out_ready held high; HOLD costs at least one cycle.
- Backpressure: in_valid may drop mid-frame, and the counter and max hold their values. in_score and in_last are ignored whenever in_ready=0.
- clear (sync, highest priority after reset): next state is IDLE, counter=0, out_valid=0, out_err=0. A beat presented in the same cycle as clear is discarded.
- out_class and out_score are driven from registers. No combinational path from in_* to out_*.
- in_ready depends only on state, so there is no combinational path from out_ready to in_ready.

Decomposition:
- Shared package bnn_pkg holds:
  - constants BNN_INPUT_SIZE=784, BNN_NUM_CLASSES=10, BNN_SCORE_WIDTH=$clog2(BNN_INPUT_SIZE+1)
  - enum argmax_state_t {IDLE, COLLECT, HOLD}
  - struct argmax_result_t {class, score, err}
- No sub-module is needed. The compare/update datapath and the FSM fit in one module of roughly 150 lines.

Test Plan:
- Scores {3,10,7,1,0,5,9,500,2,4}, in_last on beat 9, out_ready=1 -> out_class=7, out_score=500, out_err=0. out_valid rises one cycle after beat 9 and is high for exactly one cycle.
- Ties {4,4,9,2,9,0,0,9,1,1} -> out_class=2, out_score=9. All-zero frame -> out_class=0, out_score=0.
- Back-to-back frames with random in_valid gaps, and out_ready held low 5 cycles -> in_ready=0 and outputs stable through HOLD. Second frame is accepted only after the handshake, and both results are correct.
- in_last on beat 4 with scores {1,2,8,3,6} -> out_class=2, out_score=8, out_err=1. 10 beats without in_last -> correct argmax, out_err=1.
- clear asserted on beat 6 of a frame, then a fresh frame {0,...,0,784} -> out_class=9, out_score=784, with no contamination from the aborted frame.
- rst_n pulsed low asynchronously mid-frame and during HOLD -> all outputs 0 immediately. The next full frame classifies correctly.
